wb_stage: RTL and testbench

- Writeback stage of the 5-stage pipeline and the sole driver of the register file write port (wb_en, wb_data, rd_index).
- Holds the MEM/WB pipeline register and performs load-data extraction and sign/zero extension.
- Selects the writeback source and merges results from a long-latency unit (mul/div) through a 2-entry buffer. Pipeline writes have priority.

---
 rtl/wb_stage.sv | 117 +++++++++++
 tb/tb_wb_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, load extraction and register-file write arbitration.
// Pipeline writes win; a small FIFO absorbs long-latency results until a free cycle.
module wb_stage #(
    parameter int LU_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_valid,
    input  logic                      mem_reg_write,
    input  logic [4:0]                mem_rd_index,
    input  logic [1:0]                mem_wb_sel,
    input  logic [31:0]               mem_alu_result,
    input  logic [31:0]               mem_pc_plus4,
    input  logic [31:0]               mem_load_data,
    input  logic [2:0]                mem_funct3,
    input  logic [1:0]                mem_addr_lo,
    input  logic                      wb_stall,
    input  logic                      wb_flush,
    input  logic                      lu_valid,
    input  logic [4:0]                lu_rd_index,
    input  logic [31:0]               lu_data,
    output logic                      lu_ready,
    output logic [$clog2(LU_DEPTH):0] lu_count,
    output logic                      wb_en,
    output logic [31:0]               wb_data,
    output logic [4:0]                rd_index
);
    localparam int PW = $clog2(LU_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(LU_DEPTH);

    logic          r_valid, r_reg_write, r_done;
    logic [4:0]    r_rd;
    logic [1:0]    r_wb_sel, r_lo;
    logic [2:0]    r_f3;
    logic [31:0]   r_alu, r_pc4, r_ld;
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic [4:0]    r_buf_rd   [LU_DEPTH];
    logic [31:0]   r_buf_data [LU_DEPTH];

    logic        w_pw, w_nonempty, w_push, w_pop;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load, w_pipe_data;

    assign w_pw       = r_valid & r_reg_write & (r_rd != 5'd0) & ~r_done;
    assign w_nonempty = r_count != '0;
    assign lu_ready   = r_count != FULL;
    assign lu_count   = r_count;
    assign w_push     = lu_valid & lu_ready & (lu_rd_index != 5'd0);
    assign w_pop      = ~w_pw & w_nonempty;

    assign w_byte = r_ld[{r_lo, 3'b000} +: 8];
    assign w_half = r_ld[{r_lo[1], 4'b0000} +: 16];
    assign w_load = (r_f3 == 3'b000) ? {{24{w_byte[7]}}, w_byte} :
                    (r_f3 == 3'b001) ? {{16{w_half[15]}}, w_half} :
                    (r_f3 == 3'b100) ? {24'd0, w_byte} :
                    (r_f3 == 3'b101) ? {16'd0, w_half} : r_ld;
    assign w_pipe_data = (r_wb_sel == 2'b01) ? w_load :
                         (r_wb_sel == 2'b10) ? r_pc4 : r_alu;

    assign wb_en    = w_pw | w_nonempty;
    assign wb_data  = w_pw ? w_pipe_data : w_nonempty ? r_buf_data[r_head] : '0;
    assign rd_index = w_pw ? r_rd : w_nonempty ? r_buf_rd[r_head] : '0;

    // done marks a stalled instruction that already wrote, freeing later stall cycles for the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_done      <= 1'b0;
            r_rd        <= '0;
            r_wb_sel    <= '0;
            r_lo        <= '0;
            r_f3        <= '0;
            r_alu       <= '0;
            r_pc4       <= '0;
            r_ld        <= '0;
        end else if (wb_flush) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (!wb_stall) begin
            r_valid     <= mem_valid;
            r_reg_write <= mem_reg_write;
            r_done      <= 1'b0;
            r_rd        <= mem_rd_index;
            r_wb_sel    <= mem_wb_sel;
            r_lo        <= mem_addr_lo;
            r_f3        <= mem_funct3;
            r_alu       <= mem_alu_result;
            r_pc4       <= mem_pc_plus4;
            r_ld        <= mem_load_data;
        end else if (w_pw) begin
            r_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop) r_head <= r_head + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_rd[r_tail]   <= lu_rd_index;
            r_buf_data[r_tail] <= lu_data;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed literal checks plus randomized traffic compared every cycle
// against a queue-based behavioural model of the writeback stage.
module tb_wb_stage;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid, mem_reg_write, wb_stall, wb_flush, lu_valid;
    logic [4:0]  mem_rd_index, lu_rd_index;
    logic [1:0]  mem_wb_sel, mem_addr_lo;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_pc_plus4, mem_load_data, lu_data;
    logic        lu_ready, wb_en;
    logic [1:0]  lu_count;
    logic [31:0] wb_data;
    logic [4:0]  rd_index;

    int n_cmp = 0;
    int n_bad = 0;

    wb_stage #(.LU_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd_index(mem_rd_index),
        .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
        .mem_load_data(mem_load_data), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
        .wb_stall(wb_stall), .wb_flush(wb_flush),
        .lu_valid(lu_valid), .lu_rd_index(lu_rd_index), .lu_data(lu_data),
        .lu_ready(lu_ready), .lu_count(lu_count),
        .wb_en(wb_en), .wb_data(wb_data), .rd_index(rd_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: the instruction in WB is reduced to its final write value at capture.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;
    ent_t        q[$];
    bit          m_v = 0, m_rw = 0, m_wrote = 0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_val = '0;

    function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo);
        logic [31:0] b, h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * (lo / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? b - 32'd256 : b;
            3'd1: return (h >= 32768) ? h - 32'd65536 : h;
            3'd4: return b;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    function automatic bit m_pw();
        return m_v && m_rw && m_rd != 0 && !m_wrote;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit pw, acc;
        if (rst) begin
            m_v = 0; m_rw = 0; m_wrote = 0; m_rd = '0; m_val = '0;
            q.delete();
        end else begin
            pw  = m_pw();
            acc = lu_valid && q.size() < DEPTH;
            if (!pw && q.size() > 0) void'(q.pop_front());
            if (acc && lu_rd_index != 0) q.push_back('{lu_rd_index, lu_data});
            if (wb_flush) begin
                m_v = 0; m_wrote = 0;
            end else if (wb_stall) begin
                m_wrote = m_wrote || pw;
            end else begin
                m_v = mem_valid; m_rw = mem_reg_write; m_rd = mem_rd_index; m_wrote = 0;
                m_val = (mem_wb_sel == 2'b01) ? ld_val(mem_load_data, mem_funct3, mem_addr_lo) :
                        (mem_wb_sel == 2'b10) ? mem_pc_plus4 : mem_alu_result;
            end
        end
    end

    always @(negedge clk) begin
        logic        e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_d;
        if (m_pw()) begin
            e_en = 1; e_rd = m_rd; e_d = m_val;
        end else if (q.size() > 0) begin
            e_en = 1; e_rd = q[0].rd; e_d = q[0].d;
        end else begin
            e_en = 0; e_rd = '0; e_d = '0;
        end
        chk("model{en,rd,data,ready,count}",
            64'({wb_en, rd_index, wb_data, lu_ready, lu_count}),
            64'({e_en, e_rd, e_d, q.size() < DEPTH, 2'(q.size())}));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid = 0; mem_reg_write = 0; mem_rd_index = '0; mem_wb_sel = '0;
        mem_alu_result = '0; mem_pc_plus4 = '0; mem_load_data = '0; mem_funct3 = '0;
        mem_addr_lo = '0; wb_stall = 0; wb_flush = 0;
        lu_valid = 0; lu_rd_index = '0; lu_data = '0;
    endtask

    task automatic mem(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [2:0] f3, input logic [1:0] lo);
        mem_valid = 1; mem_reg_write = 1; mem_rd_index = rd; mem_wb_sel = sel;
        mem_alu_result = alu; mem_pc_plus4 = alu + 4; mem_load_data = ld;
        mem_funct3 = f3; mem_addr_lo = lo;
    endtask

    task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lu_valid = v; lu_rd_index = rd; lu_data = d;
    endtask

    logic [2:0]  ld_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  ld_lo  [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};

    initial begin
        idle();
        cyc(); cyc();
        chk("rst_en", wb_en, 0);
        chk("rst_data", wb_data, 0);
        chk("rst_rd", rd_index, 0);
        chk("rst_ready", lu_ready, 1);
        chk("rst_count", lu_count, 0);
        rst = 0;

        mem(5, 2'b00, 32'h1234, 0, 0, 0);
        cyc();
        chk("alu_en", wb_en, 1);
        chk("alu_rd", rd_index, 5);
        chk("alu_data", wb_data, 32'h00001234);
        idle(); cyc();
        chk("alu_after_en", wb_en, 0);

        for (int i = 0; i < 5; i++) begin
            mem(9, 2'b01, 32'hDEAD, 32'h80FF7F01, ld_f3[i], ld_lo[i]);
            cyc();
            chk($sformatf("load%0d_data", i), wb_data, ld_exp[i]);
        end
        idle(); cyc();

        mem(1, 0, 32'h100, 0, 0, 0); lu(1, 7, 32'hA); cyc();
        chk("lu1_count", lu_count, 1);
        chk("lu1_rd", rd_index, 1);
        mem(2, 0, 32'h200, 0, 0, 0); lu(1, 8, 32'hB); cyc();
        chk("lu2_count", lu_count, 2);
        chk("lu2_ready", lu_ready, 0);
        mem(3, 0, 32'h300, 0, 0, 0); lu(1, 9, 32'hC); cyc();
        chk("lu3_count", lu_count, 2);
        chk("lu3_rd", rd_index, 3);
        idle(); cyc();
        chk("bub1", {wb_en, rd_index, wb_data}, {1'b1, 5'd7, 32'hA});
        mem(4, 0, 32'h400, 0, 0, 0); cyc();
        chk("after_bub1_ready", lu_ready, 1);
        chk("after_bub1_count", lu_count, 1);
        chk("after_bub1_rd", rd_index, 4);
        idle(); cyc();
        chk("bub2", {wb_en, rd_index, wb_data}, {1'b1, 5'd8, 32'hB});
        cyc();
        chk("lu_drained", {wb_en, lu_count}, {1'b0, 2'd0});

        mem(1, 0, 32'h1, 0, 0, 0); lu(1, 10, 32'h10); cyc();
        mem(2, 0, 32'h2, 0, 0, 0); lu(1, 11, 32'h11); cyc();
        chk("stall_fill", lu_count, 2);
        mem(3, 0, 32'h33, 0, 0, 0); lu(0, 0, 0); cyc();
        chk("stall_c1", {wb_en, rd_index, wb_data}, {1'b1, 5'd3, 32'h33});
        idle(); wb_stall = 1; cyc();
        chk("stall_c2", {wb_en, rd_index, wb_data}, {1'b1, 5'd10, 32'h10});
        cyc();
        chk("stall_c3", {wb_en, rd_index, wb_data}, {1'b1, 5'd11, 32'h11});
        wb_stall = 0; cyc();
        chk("stall_end", {wb_en, lu_count}, {1'b0, 2'd0});

        mem(4, 0, 32'h44, 0, 0, 0); wb_flush = 1; wb_stall = 1; cyc();
        chk("flush_stall_en", wb_en, 0);
        idle(); lu(1, 0, 32'h55);
        chk("rd0_ready", lu_ready, 1);
        cyc();
        chk("rd0_discard", {wb_en, lu_count}, {1'b0, 2'd0});
        idle(); cyc();

        mem(1, 0, 32'h1, 0, 0, 0); lu(1, 12, 32'hC0); cyc();
        mem(2, 0, 32'h2, 0, 0, 0); lu(1, 13, 32'hD0); cyc();
        mem(6, 0, 32'h66, 0, 0, 0); lu(0, 0, 0); cyc();
        chk("pre_rst", {rd_index, lu_count}, {5'd6, 2'd2});
        idle(); #2 rst = 1; #1;
        chk("mid_rst", {wb_en, rd_index, wb_data, lu_ready, lu_count}, {1'b0, 5'd0, 32'd0, 1'b1, 2'd0});
        cyc(); rst = 0; cyc();
        chk("post_rst1", wb_en, 0);
        cyc();
        chk("post_rst2", {wb_en, lu_count}, {1'b0, 2'd0});

        for (int i = 0; i < 3000; i++) begin
            mem_valid      = $urandom_range(0, 9) < 7;
            mem_reg_write  = $urandom_range(0, 9) < 8;
            mem_rd_index   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            mem_wb_sel     = 2'($urandom);
            mem_alu_result = $urandom;
            mem_pc_plus4   = $urandom;
            mem_load_data  = $urandom;
            mem_funct3     = 3'($urandom);
            mem_addr_lo    = 2'($urandom);
            wb_stall       = $urandom_range(0, 3) == 0;
            wb_flush       = $urandom_range(0, 9) == 0;
            lu_valid       = $urandom_range(0, 9) < 4;
            lu_rd_index    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            lu_data        = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1;
                cyc();
                rst = 0;
            end else begin
                cyc();
            end
        end
        idle(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
